mips_mc_ctrl: RTL

- Multicycle MIPS main control FSM. It produces the 3-bit aluop code consumed by the ALU decoder, plus all datapath enables and selects.
- It sequences each instruction through fetch, decode, execute, memory and writeback states.
- It sits in the controller beside the ALU decoder and drives the multicycle datapath.
- Memory accesses use a ready handshake, so instruction and data memories may take multiple cycles.

---
 rtl/mips_mc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS main control FSM.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback. It drives the ALU decoder with a 3-bit aluop and the
// multicycle datapath with its enables and selects.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   op         opcode field from the instruction register
//   mem_ready  memory finished the current read/write this cycle
//   aluop      000 add, 001 sub, 010 R-type, 011 and, 100 or, 101 slt
//   irwrite    load instruction register (FETCH, gated by mem_ready)
//   pcwrite    unconditional PC write (FETCH gated by mem_ready, JEX)
//   branch     PC write qualified by ALU zero
//   memwrite   data memory write request
//   regwrite   register file write
//   iord       0: address = PC, 1: address = ALUOut
//   memtoreg   writeback source: 1 = memory data, 0 = ALUOut
//   regdst     1 = rd, 0 = rt
//   alusrca    0: PC, 1: register A
//   alusrcb    00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   pcsrc      00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op pulse in DECODE when op is unsupported
//   dbg_state  current state encoding
module mips_mc_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic [2:0]         aluop,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               memwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_RT  = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] SRCB_B    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_4    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_OUT  = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JMP  = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    ANDIEX  = 4'd12,
    ORIEX   = 4'd13,
    SLTIEX  = 4'd14
  } state_e;

  state_e               state_q, state_d;

  logic [ALUOP_W-1:0]   aluop_q,    aluop_d;
  logic [SEL_W-1:0]     alusrcb_q,  alusrcb_d;
  logic [SEL_W-1:0]     pcsrc_q,    pcsrc_d;
  logic                 alusrca_q,  alusrca_d;
  logic                 iord_q,     iord_d;
  logic                 branch_q,   branch_d;
  logic                 memwrite_q, memwrite_d;
  logic                 regwrite_q, regwrite_d;
  logic                 memtoreg_q, memtoreg_d;
  logic                 regdst_q,   regdst_d;
  logic                 pcwrite_q,  pcwrite_d;

  logic                 op_legal_c;
  logic                 fetch_ld_c;

  // Opcodes the FSM knows how to sequence
  always_comb begin
    op_legal_c = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: op_legal_c = 1'b1;
      default:                       op_legal_c = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_SLTI:      state_d = SLTIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      // op comes from the instruction register, stable since FETCH
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX,
      ANDIEX,
      ORIEX,
      SLTIEX:  state_d = IMMWB;
      IMMWB:   state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Moore output decode of the upcoming state, captured alongside state_q
  always_comb begin
    aluop_d    = ALU_ADD;
    alusrcb_d  = SRCB_B;
    pcsrc_d    = PCSRC_ALU;
    alusrca_d  = 1'b0;
    iord_d     = 1'b0;
    branch_d   = 1'b0;
    memwrite_d = 1'b0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    regdst_d   = 1'b0;
    pcwrite_d  = 1'b0;
    case (state_d)
      FETCH: begin
        alusrcb_d = SRCB_4;
      end
      DECODE: begin
        alusrcb_d = SRCB_IMM2;
      end
      MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
      end
      MEMRD: begin
        iord_d = 1'b1;
      end
      MEMWB: begin
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
      end
      MEMWR: begin
        iord_d     = 1'b1;
        memwrite_d = 1'b1;
      end
      RTYPEEX: begin
        alusrca_d = 1'b1;
        aluop_d   = ALU_RT;
      end
      RTYPEWB: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      BEQEX: begin
        alusrca_d = 1'b1;
        aluop_d   = ALU_SUB;
        pcsrc_d   = PCSRC_OUT;
        branch_d  = 1'b1;
      end
      ADDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        aluop_d   = ALU_ADD;
      end
      ANDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        aluop_d   = ALU_AND;
      end
      ORIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        aluop_d   = ALU_OR;
      end
      SLTIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = SRCB_IMM;
        aluop_d   = ALU_SLT;
      end
      IMMWB: begin
        regwrite_d = 1'b1;
      end
      JEX: begin
        pcsrc_d   = PCSRC_JMP;
        pcwrite_d = 1'b1;
      end
      default: begin
        aluop_d = ALU_ADD;
      end
    endcase
  end

  // State and registered outputs; reset values are the FETCH decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      aluop_q    <= ALU_ADD;
      alusrcb_q  <= SRCB_4;
      pcsrc_q    <= PCSRC_ALU;
      alusrca_q  <= 1'b0;
      iord_q     <= 1'b0;
      branch_q   <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regdst_q   <= 1'b0;
      pcwrite_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      aluop_q    <= aluop_d;
      alusrcb_q  <= alusrcb_d;
      pcsrc_q    <= pcsrc_d;
      alusrca_q  <= alusrca_d;
      iord_q     <= iord_d;
      branch_q   <= branch_d;
      memwrite_q <= memwrite_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      regdst_q   <= regdst_d;
      pcwrite_q  <= pcwrite_d;
    end
  end

  // FETCH loads IR and advances PC only in the cycle memory delivers;
  // reset masks it so a ready memory cannot write during reset
  assign fetch_ld_c = reset & (state_q == FETCH) & mem_ready;

  assign irwrite    = fetch_ld_c;
  assign pcwrite    = pcwrite_q | fetch_ld_c;
  assign illegal_op = reset & (state_q == DECODE) & ~op_legal_c;

  assign aluop      = aluop_q;
  assign alusrcb    = alusrcb_q;
  assign pcsrc      = pcsrc_q;
  assign alusrca    = alusrca_q;
  assign iord       = iord_q;
  assign branch     = branch_q;
  assign memwrite   = memwrite_q;
  assign regwrite   = regwrite_q;
  assign memtoreg   = memtoreg_q;
  assign regdst     = regdst_q;
  assign dbg_state  = STATE_W'(state_q);

endmodule
